// File: rtl/vga_sprite_engine_if.sv
// Avalon-MM slave bus carrying register accesses into the VGA sprite engine.
interface vga_sprite_engine_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [8:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/vga_sprite_engine.sv
// N-sprite compositor between vga_counters and the VGA DAC with double-buffered sprite registers.
// Optional per-sprite collision status and irq are built when SPRITE_COLLISION_EN is defined.
module vga_sprite_engine #(
   parameter int NSPR    = 4,
   parameter int SW      = 32,
   parameter int SH      = 32,
   parameter int HSHIFT  = 1,
   parameter int VACTIVE = 480,
   parameter int RAW     = $clog2(SW*SH)
) (
   input  logic                clk,
   input  logic                reset,
   vga_sprite_engine_if.slave  bus,
   input  logic [10:0]         hcount,
   input  logic [9:0]          vcount,
   input  logic                blank_n_in,
   output logic [NSPR*RAW-1:0] rom_addr,
   input  logic [NSPR*16-1:0]  rom_data,
   output logic [7:0]          vga_r,
   output logic [7:0]          vga_g,
   output logic [7:0]          vga_b,
   output logic                blank_n_out
`ifdef SPRITE_COLLISION_EN
   ,
   output logic                irq
`endif
);

   function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
      return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
   endfunction

   function automatic logic sprite_hit(input logic [11:0] px, input logic [11:0] py,
                                       input logic [11:0] x,  input logic [11:0] y);
      return (px >= x) && (px < x + 12'(SW)) && (py >= y) && (py < y + 12'(SH));
   endfunction

   function automatic logic [RAW-1:0] sprite_addr(input logic [11:0] dx, input logic [11:0] dy);
      return RAW'(32'(dy) * 32'(SW) + 32'(dx));
   endfunction

   logic        wr_s;
   logic        rd_s;
   logic [6:0]  idx_s;
   logic [1:0]  fld_s;
   logic        commit_s;
   logic        unused_s;

   assign wr_s     = bus.chipselect && bus.write;
   assign rd_s     = bus.chipselect && bus.read;
   assign idx_s    = bus.address[8:2];
   assign fld_s    = bus.address[1:0];
   assign commit_s = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
   assign unused_s = ^bus.writedata[31:24];

   logic [10:0]     pend_x_q  [NSPR];
   logic [10:0]     pend_x_d  [NSPR];
   logic [10:0]     act_x_q   [NSPR];
   logic [9:0]      pend_y_q  [NSPR];
   logic [9:0]      pend_y_d  [NSPR];
   logic [9:0]      act_y_q   [NSPR];
   logic [NSPR-1:0] pend_en_q;
   logic [NSPR-1:0] pend_en_d;
   logic [NSPR-1:0] act_en_q;
   logic [23:0]     pend_bg_q;
   logic [23:0]     pend_bg_d;
   logic [23:0]     act_bg_q;
   logic [15:0]     pend_key_q;
   logic [15:0]     pend_key_d;
   logic [15:0]     act_key_q;

   // Pending register next-state from Avalon writes
   always_comb begin
      pend_x_d  = pend_x_q;
      pend_y_d  = pend_y_q;
      pend_en_d = pend_en_q;
      for (int i = 0; i < NSPR; i++) begin
         pend_x_d[i]  = (wr_s && idx_s == 7'(i) && fld_s == 2'd0) ? bus.writedata[10:0] : pend_x_q[i];
         pend_y_d[i]  = (wr_s && idx_s == 7'(i) && fld_s == 2'd1) ? bus.writedata[9:0]  : pend_y_q[i];
         pend_en_d[i] = (wr_s && idx_s == 7'(i) && fld_s == 2'd2) ? bus.writedata[0]    : pend_en_q[i];
      end
      pend_bg_d  = (wr_s && idx_s == 7'(NSPR) && fld_s == 2'd0) ? bus.writedata[23:0] : pend_bg_q;
      pend_key_d = (wr_s && idx_s == 7'(NSPR) && fld_s == 2'd1) ? bus.writedata[15:0] : pend_key_q;
   end

   // Pending and active register banks; active reads the old pending value on a commit-cycle write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NSPR; i++) begin
            pend_x_q[i] <= 11'd0;
            pend_y_q[i] <= 10'd0;
            act_x_q[i]  <= 11'd0;
            act_y_q[i]  <= 10'd0;
         end
         pend_en_q  <= {NSPR{1'b0}};
         act_en_q   <= {NSPR{1'b0}};
         pend_bg_q  <= 24'hFFFFFF;
         act_bg_q   <= 24'hFFFFFF;
         pend_key_q <= 16'hF81F;
         act_key_q  <= 16'hF81F;
      end else begin
         pend_x_q   <= pend_x_d;
         pend_y_q   <= pend_y_d;
         pend_en_q  <= pend_en_d;
         pend_bg_q  <= pend_bg_d;
         pend_key_q <= pend_key_d;
         if (commit_s) begin
            act_x_q   <= pend_x_q;
            act_y_q   <= pend_y_q;
            act_en_q  <= pend_en_q;
            act_bg_q  <= pend_bg_q;
            act_key_q <= pend_key_q;
         end else begin
            act_x_q   <= act_x_q;
            act_y_q   <= act_y_q;
            act_en_q  <= act_en_q;
            act_bg_q  <= act_bg_q;
            act_key_q <= act_key_q;
         end
      end
   end

   logic [31:0] status_rd_s;
   logic [31:0] sys_rd_s;
   logic [31:0] rd_mux_s;
   logic [31:0] readdata_d;
   logic [31:0] readdata_q;

   // Read mux over pending values; unmapped locations return zero
   always_comb begin
      rd_mux_s = 32'd0;
      for (int i = 0; i < NSPR; i++) begin
         rd_mux_s = (idx_s == 7'(i) && fld_s == 2'd0) ? {21'd0, pend_x_q[i]}  : rd_mux_s;
         rd_mux_s = (idx_s == 7'(i) && fld_s == 2'd1) ? {22'd0, pend_y_q[i]}  : rd_mux_s;
         rd_mux_s = (idx_s == 7'(i) && fld_s == 2'd2) ? {31'd0, pend_en_q[i]} : rd_mux_s;
      end
      case (fld_s)
         2'd0:    sys_rd_s = {8'd0, pend_bg_q};
         2'd1:    sys_rd_s = {16'd0, pend_key_q};
         2'd2:    sys_rd_s = status_rd_s;
         default: sys_rd_s = 32'd0;
      endcase
      rd_mux_s   = (idx_s == 7'(NSPR)) ? sys_rd_s : rd_mux_s;
      readdata_d = rd_s ? rd_mux_s : readdata_q;
   end

   // Read data register, one cycle after the strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_q <= 32'd0;
      end else begin
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;

   logic [11:0]         px_s;
   logic [11:0]         py_s;
   logic [NSPR-1:0]     hit_s;
   logic [NSPR*RAW-1:0] rom_addr_d;
   logic [NSPR*RAW-1:0] rom_addr_q;
   logic [NSPR-1:0]     hit1_q;
   logic [NSPR-1:0]     hit2_q;
   logic                blank1_q;
   logic                blank2_q;
   logic                blank3_q;

   assign px_s = {1'b0, hcount >> HSHIFT};
   assign py_s = {2'b00, vcount};

   // S0: hit test in 12 bits so sprites clip at the edge instead of wrapping
   always_comb begin
      hit_s      = {NSPR{1'b0}};
      rom_addr_d = rom_addr_q;
      for (int i = 0; i < NSPR; i++) begin
         hit_s[i] = act_en_q[i] &&
                    sprite_hit(px_s, py_s, {1'b0, act_x_q[i]}, {2'b00, act_y_q[i]});
         rom_addr_d[i*RAW +: RAW] = hit_s[i] ?
            sprite_addr(px_s - {1'b0, act_x_q[i]}, py_s - {2'b00, act_y_q[i]}) :
            rom_addr_q[i*RAW +: RAW];
      end
   end

   // S0->S1->S2 pipeline registers; the ROM supplies the S1->S2 data stage itself
   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr_q <= {(NSPR*RAW){1'b0}};
         hit1_q     <= {NSPR{1'b0}};
         hit2_q     <= {NSPR{1'b0}};
         blank1_q   <= 1'b0;
         blank2_q   <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         hit1_q     <= hit_s;
         hit2_q     <= hit1_q;
         blank1_q   <= blank_n_in;
         blank2_q   <= blank1_q;
      end
   end

   assign rom_addr = rom_addr_q;

   logic [NSPR-1:0] opaque_s;
   logic [23:0]     colour_s;
   logic [23:0]     vga_d;
   logic [23:0]     vga_q;

   // S2: lowest-index opaque sprite wins, otherwise background
   always_comb begin
      opaque_s = {NSPR{1'b0}};
      colour_s = act_bg_q;
      for (int i = 0; i < NSPR; i++) begin
         opaque_s[i] = hit2_q[i] && (rom_data[i*16 +: 16] != act_key_q);
      end
      for (int i = NSPR - 1; i >= 0; i--) begin
         colour_s = opaque_s[i] ? rgb565_to_888(rom_data[i*16 +: 16]) : colour_s;
      end
      vga_d = blank2_q ? colour_s : 24'd0;
   end

   // Registered pixel output and aligned blank
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_q    <= 24'd0;
         blank3_q <= 1'b0;
      end else begin
         vga_q    <= vga_d;
         blank3_q <= blank2_q;
      end
   end

   assign vga_r       = vga_q[23:16];
   assign vga_g       = vga_q[15:8];
   assign vga_b       = vga_q[7:0];
   assign blank_n_out = blank3_q;

`ifdef SPRITE_COLLISION_EN
   function automatic logic more_than_one(input logic [NSPR-1:0] v);
      return (v & (v - NSPR'(1'b1))) != {NSPR{1'b0}};
   endfunction

   logic [NSPR-1:0] coll_s;
   logic [NSPR-1:0] acc_d;
   logic [NSPR-1:0] acc_q;
   logic [NSPR-1:0] status_d;
   logic [NSPR-1:0] status_q;
   logic            status_wr_s;
   logic            irq_q;

   assign status_wr_s = wr_s && (idx_s == 7'(NSPR)) && (fld_s == 2'd2);
   assign status_rd_s = {{(32-NSPR){1'b0}}, status_q};

   // Collision accumulation; commit takes priority over a status-clear write
   always_comb begin
      coll_s   = (blank2_q && more_than_one(opaque_s)) ? opaque_s : {NSPR{1'b0}};
      acc_d    = commit_s ? {NSPR{1'b0}} : (acc_q | coll_s);
      status_d = commit_s ? acc_q : (status_wr_s ? {NSPR{1'b0}} : status_q);
   end

   // Collision state and interrupt registers
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= {NSPR{1'b0}};
         status_q <= {NSPR{1'b0}};
         irq_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         status_q <= status_d;
         irq_q    <= |status_d;
      end
   end

   assign irq = irq_q;
`else
   assign status_rd_s = 32'd0;
`endif

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed scoreboard bench for vga_sprite_engine: pixel expectations are queued at drive time
// and popped three clocks later; register reads are compared one clock after the strobe.
module tb_vga_sprite_engine;
   localparam int NSPR = 4;
   localparam int SW   = 32;
   localparam int SH   = 32;
   localparam int RAW  = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic [10:0]         hcount;
   logic [9:0]          vcount;
   logic                blank_n_in;
   logic [NSPR*RAW-1:0] rom_addr;
   logic [NSPR*16-1:0]  rom_data;
   logic [7:0]          vga_r;
   logic [7:0]          vga_g;
   logic [7:0]          vga_b;
   logic                blank_n_out;
`ifdef SPRITE_COLLISION_EN
   logic                irq;
`endif

   vga_sprite_engine_if bus ();

   vga_sprite_engine #(.NSPR(NSPR), .SW(SW), .SH(SH), .HSHIFT(1), .VACTIVE(480)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .hcount(hcount), .vcount(vcount), .blank_n_in(blank_n_in),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .blank_n_out(blank_n_out)
`ifdef SPRITE_COLLISION_EN
      , .irq(irq)
`endif
   );

   logic [15:0] rom_val  [NSPR];
   int          key_addr [NSPR];

   function automatic logic [15:0] rom_word(int i, int a);
      return (a == key_addr[i]) ? 16'hF81F : rom_val[i];
   endfunction

   // Sprite ROMs with one clock of read latency
   always @(posedge clk) begin
      for (int i = 0; i < NSPR; i++) begin
         rom_data[i*16 +: 16] <= rom_word(i, int'(rom_addr[i*RAW +: RAW]));
      end
   end

   int          p_x [NSPR];
   int          p_y [NSPR];
   bit          p_en[NSPR];
   int          m_x [NSPR];
   int          m_y [NSPR];
   bit          m_en[NSPR];
   logic [23:0] p_bg, m_bg;
   logic [15:0] p_key, m_key;

   typedef struct {
      bit          chk;
      logic [24:0] exp;
      string       tag;
   } ent_t;

   ent_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [23:0] expand(logic [15:0] c);
      int r, g, b;
      r = int'(c[15:11]);
      g = int'(c[10:5]);
      b = int'(c[4:0]);
      return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
   endfunction

   function automatic logic [24:0] model_pix(int h, int v, bit b);
      logic [24:0] r;
      logic [15:0] d;
      bit          done;
      int          px;
      if (!b) return 25'd0;
      px   = h / 2;
      r    = {1'b1, m_bg};
      done = 1'b0;
      for (int i = 0; i < NSPR; i++) begin
         if (!done && m_en[i] && px >= m_x[i] && px < m_x[i] + SW && v >= m_y[i] && v < m_y[i] + SH) begin
            d = rom_word(i, (v - m_y[i]) * SW + (px - m_x[i]));
            if (d != m_key) begin
               r    = {1'b1, expand(d)};
               done = 1'b1;
            end
         end
      end
      return r;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NSPR; i++) begin
         p_x[i] = 0; p_y[i] = 0; p_en[i] = 1'b0;
         m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0;
      end
      p_bg = 24'hFFFFFF; m_bg = 24'hFFFFFF;
      p_key = 16'hF81F;  m_key = 16'hF81F;
   endtask

   task automatic model_write(int idx, int fld, logic [31:0] wd);
      if (idx < NSPR) begin
         if (fld == 0) p_x[idx] = int'(wd[10:0]);
         if (fld == 1) p_y[idx] = int'(wd[9:0]);
         if (fld == 2) p_en[idx] = wd[0];
      end else if (idx == NSPR) begin
         if (fld == 0) p_bg = wd[23:0];
         if (fld == 1) p_key = wd[15:0];
      end
   endtask

   // One clock: drive pixel and bus, queue the expectation, retire the entry three clocks old
   task automatic step(int h, int v, bit b, string tag = "pix", bit wr = 1'b0, int idx = 0,
                       int fld = 0, logic [31:0] wd = 32'd0, bit rd = 1'b0);
      ent_t e;
      hcount         = 11'(h);
      vcount         = 10'(v);
      blank_n_in     = b;
      bus.chipselect = wr | rd;
      bus.write      = wr;
      bus.read       = rd;
      bus.address    = {7'(idx), 2'(fld)};
      bus.writedata  = wd;
      e.chk = 1'b1;
      e.exp = model_pix(h, v, b);
      e.tag = $sformatf("%s@%0d,%0d", tag, h / 2, v);
      q.push_back(e);
      if (h == 0 && v == 480) begin
         m_x = p_x; m_y = p_y; m_en = p_en; m_bg = p_bg; m_key = p_key;
      end
      if (wr) model_write(idx, fld, wd);
      @(posedge clk);
      @(negedge clk);
      if (q.size() > 2) begin
         e = q.pop_front();
         if (e.chk) check(e.tag, {7'd0, blank_n_out, vga_r, vga_g, vga_b}, {7'd0, e.exp});
      end
   endtask

   task automatic pix(int px, int v, string tag);
      step(px * 2 + (px & 1), v, 1'b1, tag);
   endtask

   task automatic idle(int n);
      repeat (n) step(1, 0, 1'b0, "idle");
   endtask

   task automatic bus_write(int idx, int fld, logic [31:0] wd);
      step(1, 0, 1'b0, "wr", 1'b1, idx, fld, wd);
   endtask

   task automatic bus_read(int idx, int fld, logic [31:0] expv, string tag);
      step(1, 0, 1'b0, "rd", 1'b0, idx, fld, 32'd0, 1'b1);
      check(tag, bus.readdata, expv);
   endtask

   task automatic commit();
      step(0, 480, 1'b0, "commit");
   endtask

   task automatic do_reset(int n);
      reset          = 1'b1;
      hcount         = 11'd430;
      vcount         = 10'd65;
      blank_n_in     = 1'b1;
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      q.delete();
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check("reset_out", {7'd0, blank_n_out, vga_r, vga_g, vga_b}, 32'd0);
      end
      model_reset();
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NSPR; i++) begin
         rom_val[i]  = 16'h0000;
         key_addr[i] = -1;
      end
      bus.address   = 9'd0;
      bus.writedata = 32'd0;
      @(negedge clk);
      do_reset(3);

      // Background only, blank toggling shows the 3-clock lag
      pix(0, 10, "bg"); pix(5, 10, "bg"); pix(320, 10, "bg"); pix(639, 10, "bg");
      step(2, 11, 1'b0, "blank"); pix(3, 11, "bg"); step(8, 11, 1'b0, "blank");
      bus_read(0, 0, 32'd0, "rst_x0");
      bus_read(NSPR, 0, 32'h00FFFFFF, "rst_bg");
      bus_read(NSPR, 1, 32'h0000F81F, "rst_key");
      bus_read(NSPR, 2, 32'd0, "rst_status");
      bus_read(5, 0, 32'd0, "unmapped_idx");
      bus_read(0, 3, 32'd0, "unmapped_fld");

      // Sprite 0 at (100,50), solid red
      rom_val[0] = 16'hF800;
      bus_write(0, 0, 32'd100);
      bus_write(0, 1, 32'd50);
      bus_write(0, 2, 32'd1);
      bus_read(0, 0, 32'd100, "pend_x0");
      pix(100, 50, "precommit");
      commit();
      pix(99, 50, "left_out"); pix(100, 50, "left_in"); pix(115, 60, "mid");
      pix(131, 81, "corner"); pix(132, 50, "right_out"); pix(100, 49, "top_out");
      pix(100, 82, "bot_out"); pix(131, 50, "right_in");

      // Mid-frame move becomes visible only after the next commit
      bus_write(0, 0, 32'd200);
      bus_read(0, 0, 32'd200, "pend_x0_move");
      pix(100, 55, "old_pos"); pix(200, 55, "new_pos_early");
      commit();
      pix(100, 55, "old_gone"); pix(200, 55, "new_pos");

      // Overlap with a transparent pixel in sprite 0, new background
      rom_val[1]  = 16'h07E0;
      key_addr[0] = 15 * SW + 15;
      bus_write(1, 0, 32'd210);
      bus_write(1, 1, 32'd60);
      bus_write(1, 2, 32'd1);
      bus_write(NSPR, 0, 32'h00123456);
      commit();
      pix(215, 65, "key_shows_s1"); pix(214, 65, "s0_on_top"); pix(205, 65, "s0_only");
      pix(235, 65, "s1_only"); pix(245, 65, "bg_new"); pix(215, 49, "above");

      // Write on the commit cycle: active keeps the old value for this frame
      step(0, 480, 1'b0, "commit_wr", 1'b1, 1, 0, 32'd300);
      pix(235, 65, "s1_old_pos");
      bus_read(1, 0, 32'd300, "pend_x1");
      pix(300, 65, "s1_not_yet");
      commit();
      pix(300, 65, "s1_moved"); pix(215, 65, "key_now_bg");

      // Right-edge clipping, no wrap, and x=SW-1 fully visible
      rom_val[2] = 16'h001F;
      rom_val[3] = 16'hFFE0;
      bus_write(2, 0, 32'd630); bus_write(2, 1, 32'd100); bus_write(2, 2, 32'd1);
      bus_write(3, 0, 32'd31);  bus_write(3, 1, 32'd100); bus_write(3, 2, 32'd1);
      commit();
      pix(629, 110, "edge_before"); pix(630, 110, "edge_first"); pix(639, 110, "edge_last");
      pix(0, 110, "nowrap0"); pix(10, 110, "nowrap10"); pix(21, 110, "nowrap21");
      pix(30, 110, "x31_left"); pix(31, 110, "x31_first"); pix(62, 110, "x31_last");
      pix(63, 110, "x31_miss");
      step(1280, 110, 1'b0, "hblank");
      bus_write(3, 0, 32'd2040);
      commit();
      pix(0, 110, "wrap12_0"); pix(7, 110, "wrap12_7"); pix(23, 110, "wrap12_23");

      // Reset mid-frame returns everything to defaults
      idle(2);
      do_reset(2);
      pix(235, 65, "post_rst"); pix(630, 110, "post_rst");
      bus_read(1, 2, 32'd0, "post_rst_en1");
      bus_read(NSPR, 0, 32'h00FFFFFF, "post_rst_bg");

`ifdef SPRITE_COLLISION_EN
      for (int i = 0; i < NSPR; i++) key_addr[i] = -1;
      rom_val[1] = 16'h07E0;
      rom_val[2] = 16'h001F;
      bus_write(1, 0, 32'd400); bus_write(1, 1, 32'd300); bus_write(1, 2, 32'd1);
      bus_write(2, 0, 32'd410); bus_write(2, 1, 32'd300); bus_write(2, 2, 32'd1);
      commit();
      commit();
      bus_read(NSPR, 2, 32'd0, "status_clear");
      check("irq_low", {31'd0, irq}, 32'd0);
      pix(415, 305, "overlap"); pix(420, 310, "overlap"); pix(405, 305, "s1_alone");
      idle(3);
      commit();
      bus_read(NSPR, 2, 32'd6, "status_coll");
      check("irq_high", {31'd0, irq}, 32'd1);
      bus_write(NSPR, 2, 32'd0);
      check("irq_cleared", {31'd0, irq}, 32'd0);
      bus_read(NSPR, 2, 32'd0, "status_after_clr");
`endif

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
